envm_fault_map_loader: RTL
==========================

# envm_fault_map_loader

Reads the per-row faulty-PE map that the diagnostic loop chains stored in eNVM and rebuilds it as a full SYSTOLIC_SIZE×SYSTOLIC_SIZE fault matrix. Sits between eNVM and bisr_weight_allocation: it sequences row reads out of eNVM, then delivers the matrix to the BISR over a write-enable/ready handshake. It also produces row/column fault summaries and a total faulty-PE count for recovery decisions.

## Interface
- SYSTOLIC_SIZE, 8, array dimension (rows = columns)
- ADDR_WIDTH, $clog2(SYSTOLIC_SIZE), eNVM row-address width
- COUNT_WIDTH, $clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE+1), fault-count width

Ports:
- clk  input  1  single clock for the whole block
- rst  input  1  reset, asynchronous, active-high
- load_start  input  1  start pulse; sampled only in IDLE
- envm_rd_en  output  1  eNVM row-read strobe
- envm_rd_addr  output  ADDR_WIDTH  row index being read
- envm_rd_data  input  SYSTOLIC_SIZE  row fault vector, bit c = PE(r,c) faulty; valid exactly 1 cycle after envm_rd_en
- envm_rd_parity  input  1  even-parity bit over envm_rd_data, same timing as data
- envm_wr_en  output  1  matrix valid to BISR; held until accepted
- wr_ready  input  1  BISR accepts matrix when high with envm_wr_en
- envm_faulty_patterns_flat  output  SYSTOLIC_SIZE*SYSTOLIC_SIZE  bit r*SYSTOLIC_SIZE+c = PE(r,c) faulty
- row_fault_summary  output  SYSTOLIC_SIZE  bit r = any fault in row r
- col_fault_summary  output  SYSTOLIC_SIZE  bit c = any fault in column c
- fault_count  output  COUNT_WIDTH  total faulty PEs
- busy  output  1  high in every state except IDLE
- load_done  output  1  one-cycle completion pulse
- parity_error  output  1  sticky parity failure flag

## Operation
- States: IDLE, RD, CAP, WR, DONE.
- IDLE: load_start=1 → clear matrix, summaries, fault_count, parity_error; row=0; → RD. load_start in any other state is ignored.
- RD: envm_rd_en=1, envm_rd_addr=row; → CAP.
- CAP: capture envm_rd_data into matrix row `row`; row_fault_summary[row] = |data; col_fault_summary |= data; fault_count += popcount(data). If row==SYSTOLIC_SIZE-1 → WR, else row+1 → RD.
- WR: envm_wr_en=1; stays until wr_ready=1 sampled, then → DONE. wr_ready outside WR is ignored.
- DONE: load_done=1 for one cycle; → IDLE.
- Outputs matrix/summaries/count hold their values after DONE until next accepted load_start or reset.
- fault_count saturates never needed: width covers SYSTOLIC_SIZE² exactly.
- Reset (any time, incl. mid-load or mid-WR): state IDLE, all outputs 0; a pending handshake is dropped.

## Timing
- Reset values: every output 0.
- load_start accepted at edge 0 → RD in cycle 1; row r read in cycle 1+2r, captured in cycle 2+2r.
- envm_wr_en first high in cycle 2·SYSTOLIC_SIZE+1 (17 for size 8); envm_faulty_patterns_flat and fault_count stable from that cycle.
- wr_ready high in first WR cycle → load_done in cycle 2·SYSTOLIC_SIZE+2; each extra wr_ready-low cycle adds one.
- Minimum load_start-to-load_start spacing: 2·SYSTOLIC_SIZE+3 cycles.

## Configuration
- FAULT_MAP_PARITY_EN defined: in CAP, if ^{envm_rd_data, envm_rd_parity} != 0, parity_error set (sticky), row still captured, FSM goes directly to DONE (no WR, envm_wr_en never asserted); load_done still pulses.
- Not defined: envm_rd_parity ignored, parity_error tied 0, all rows always loaded and delivered.

## Test plan
- Fault-free map (all rows 0), wr_ready held 1 → envm_wr_en high one cycle at cycle 17, matrix 0, fault_count=0, load_done at cycle 18.
- Single fault PE(3,5) (row 3 data 8'b0010_0000) → flat bit 29 set only, row_fault_summary=8'h08, col_fault_summary=8'h20, fault_count=1.
- Row 7 all faulty plus PE(0,0) → fault_count=9, row_fault_summary=8'h81, col_fault_summary=8'hFF; wr_ready held low 4 cycles → envm_wr_en held 5 cycles, load_done 1 cycle after acceptance.
- load_start pulsed during RD/CAP of row 2 → ignored, sequence and addresses 0..7 unchanged; rst asserted during WR → all outputs 0 same cycle, no load_done.
- FAULT_MAP_PARITY_EN defined, bad parity on row 4 → parity_error=1, no envm_wr_en, load_done one cycle after row-4 capture; next load_start clears parity_error.
- Back-to-back loads with different maps → second result fully replaces first (no stale bits, count restarts from 0).

Source files
------------

// File: rtl/envm_fault_map_loader_if.sv
// envm_fault_map_loader_if: eNVM row-read and BISR matrix-write handshake bundle
// Signals:
//   envm_rd_en / envm_rd_addr      loader -> eNVM row-read strobe and row index
//   envm_rd_data / envm_rd_parity  eNVM -> loader row fault vector and even parity (1 cycle after strobe)
//   envm_wr_en / wr_ready          loader -> BISR matrix valid, BISR -> loader accept
// Modports: master (loader side), slave (eNVM/BISR side)
interface envm_fault_map_loader_if #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
);
    logic                     envm_rd_en;
    logic [ADDR_WIDTH-1:0]    envm_rd_addr;
    logic [SYSTOLIC_SIZE-1:0] envm_rd_data;
    logic                     envm_rd_parity;
    logic                     envm_wr_en;
    logic                     wr_ready;
    modport master (output envm_rd_en, envm_rd_addr, envm_wr_en,
                    input  envm_rd_data, envm_rd_parity, wr_ready);
    modport slave  (input  envm_rd_en, envm_rd_addr, envm_wr_en,
                    output envm_rd_data, envm_rd_parity, wr_ready);
endinterface

// File: rtl/envm_fault_map_loader.sv
// envm_fault_map_loader: rebuilds the faulty-PE matrix from per-row eNVM records and hands it to BISR
// Ports:
//   clk, rst (async, active-high)   clock and reset
//   load_start                      start pulse, honoured only when idle
//   bus (master modport)            eNVM row reads and BISR write handshake
//   envm_faulty_patterns_flat       bit r*SYSTOLIC_SIZE+c = PE(r,c) faulty
//   row_fault_summary               bit r = any fault in row r
//   col_fault_summary               bit c = any fault in column c
//   fault_count                     total faulty PEs
//   busy, load_done, parity_error   status: not idle, one-cycle completion, sticky parity failure
// Build option: define FAULT_MAP_PARITY_EN to check row parity and abort delivery on a bad row.
module envm_fault_map_loader #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE),
    parameter int COUNT_WIDTH   = $clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE+1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   load_start,
    envm_fault_map_loader_if.master                bus,
    output logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] envm_faulty_patterns_flat,
    output logic [SYSTOLIC_SIZE-1:0]               row_fault_summary,
    output logic [SYSTOLIC_SIZE-1:0]               col_fault_summary,
    output logic [COUNT_WIDTH-1:0]                 fault_count,
    output logic                                   busy,
    output logic                                   load_done,
    output logic                                   parity_error
);
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;
    state_t state;
    assign busy = state != IDLE;
`ifndef FAULT_MAP_PARITY_EN
    logic unused_parity;
    assign unused_parity = bus.envm_rd_parity;
    assign parity_error  = 1'b0;
`endif
    // envm_rd_addr doubles as the row counter; rd_en/wr_en/load_done are set on entry to their state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                     <= IDLE;
            bus.envm_rd_en            <= 1'b0;
            bus.envm_rd_addr          <= '0;
            bus.envm_wr_en            <= 1'b0;
            envm_faulty_patterns_flat <= '0;
            row_fault_summary         <= '0;
            col_fault_summary         <= '0;
            fault_count               <= '0;
            load_done                 <= 1'b0;
`ifdef FAULT_MAP_PARITY_EN
            parity_error              <= 1'b0;
`endif
        end else begin
            bus.envm_rd_en <= 1'b0;
            load_done      <= 1'b0;
            case (state)
                IDLE: if (load_start) begin
                    envm_faulty_patterns_flat <= '0;
                    row_fault_summary         <= '0;
                    col_fault_summary         <= '0;
                    fault_count               <= '0;
`ifdef FAULT_MAP_PARITY_EN
                    parity_error              <= 1'b0;
`endif
                    bus.envm_rd_addr          <= '0;
                    bus.envm_rd_en            <= 1'b1;
                    state                     <= RD;
                end
                RD: state <= CAP;
                CAP: begin
                    envm_faulty_patterns_flat[int'(bus.envm_rd_addr)*SYSTOLIC_SIZE +: SYSTOLIC_SIZE] <= bus.envm_rd_data;
                    row_fault_summary[bus.envm_rd_addr] <= |bus.envm_rd_data;
                    col_fault_summary <= col_fault_summary | bus.envm_rd_data;
                    fault_count       <= fault_count + COUNT_WIDTH'($countones(bus.envm_rd_data));
`ifdef FAULT_MAP_PARITY_EN
                    // a corrupted row is kept for inspection but the matrix is never delivered
                    if (^{bus.envm_rd_data, bus.envm_rd_parity}) begin
                        parity_error <= 1'b1;
                        load_done    <= 1'b1;
                        state        <= DONE;
                    end else
`endif
                    if (bus.envm_rd_addr == ADDR_WIDTH'(SYSTOLIC_SIZE-1)) begin
                        bus.envm_wr_en <= 1'b1;
                        state          <= WR;
                    end else begin
                        bus.envm_rd_addr <= bus.envm_rd_addr + 1'b1;
                        bus.envm_rd_en   <= 1'b1;
                        state            <= RD;
                    end
                end
                WR: if (bus.wr_ready) begin
                    bus.envm_wr_en <= 1'b0;
                    load_done      <= 1'b1;
                    state          <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
